// File: rtl/cmos_frame_ctrl.sv
// Frame gating between the CMOS capture path and the SDRAM write FIFO: start-up frame skip,
// whole-frame write gating, ping-pong bank select and per-frame pixel-count check.
// Optional FRAME_DIV_EN: capture only one frame in FRAME_DIV.
module cmos_frame_ctrl #(
   parameter int FRAME_SKIP = 10,
   parameter int FRAME_DIV  = 2
) (
   input  logic        cam_pclk,
   input  logic        rst_n,
   input  logic        init_done,
   input  logic        frame_en,
   input  logic        rd_busy,
   input  logic        cmos_frame_vsync,
   input  logic        cmos_frame_valid,
   input  logic [15:0] cmos_frame_data,
   input  logic [27:0] sdram_addr_max,
   output logic        wr_en,
   output logic [15:0] wr_data,
   output logic        wr_load,
   output logic        wr_bank,
   output logic        frame_done,
   output logic [15:0] frame_cnt,
   output logic [7:0]  err_cnt
);

   typedef enum logic [1:0] {IDLE, SKIP, ARM, CAPT} state_t;

   state_t      state_q, state_d;
   logic        vsync_q;
   logic        vs_rise;
   logic [15:0] skip_q, skip_d;
   logic [27:0] pix_q, pix_d, pix_end;
   logic        act_q, act_d;
   logic        div_ok;
   logic        bank_n;
   logic        wr_en_q, wr_en_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic        wr_load_q, wr_load_d;
   logic        wr_bank_q, wr_bank_d;
   logic        done_q, done_d;
   logic [15:0] fcnt_q, fcnt_d;
   logic [7:0]  ecnt_q, ecnt_d;

   assign vs_rise = cmos_frame_vsync & ~vsync_q;

   // A pixel arriving with vs_rise still belongs to the frame being closed.
   assign pix_end = (state_q == CAPT && act_q && cmos_frame_valid && pix_q != '1)
                    ? pix_q + 28'd1 : pix_q;

`ifdef FRAME_DIV_EN
   logic [15:0] div_q, div_d;

   assign div_ok = (div_q == 16'd0);

   always_comb begin
      div_d = div_q;
      if (init_done && vs_rise && (state_q == ARM || state_q == CAPT))
         div_d = (div_q == 16'(FRAME_DIV - 1)) ? 16'd0 : div_q + 16'd1;
   end

   always_ff @(posedge cam_pclk or negedge rst_n) begin
      if (!rst_n) div_q <= '0;
      else        div_q <= div_d;
   end
`else
   assign div_ok = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      skip_d    = skip_q;
      pix_d     = pix_q;
      act_d     = act_q;
      bank_n    = wr_bank_q;
      wr_en_d   = 1'b0;
      wr_data_d = wr_data_q;
      wr_load_d = 1'b0;
      wr_bank_d = wr_bank_q;
      done_d    = 1'b0;
      fcnt_d    = fcnt_q;
      ecnt_d    = ecnt_q;

      if (state_q == CAPT && act_q) begin
         wr_en_d = cmos_frame_valid;
         pix_d   = pix_end;
         if (cmos_frame_valid) wr_data_d = cmos_frame_data;
      end

      case (state_q)
         IDLE: if (init_done) begin
            skip_d  = '0;
            state_d = (FRAME_SKIP == 0) ? ARM : SKIP;
         end
         SKIP: if (vs_rise) begin
            if (skip_q == 16'(FRAME_SKIP - 1)) state_d = ARM;
            else                               skip_d  = skip_q + 16'd1;
         end
         ARM: if (vs_rise && frame_en && div_ok) begin
            state_d   = CAPT;
            act_d     = 1'b1;
            pix_d     = '0;
            wr_load_d = 1'b1;
         end
         CAPT: if (vs_rise) begin
            if (act_q) begin
               if (pix_end == sdram_addr_max) begin
                  done_d = 1'b1;
                  fcnt_d = fcnt_q + 16'd1;
                  if (!rd_busy) bank_n = ~wr_bank_q;
               end else if (ecnt_q != 8'hFF) begin
                  ecnt_d = ecnt_q + 8'd1;
               end
            end
            wr_bank_d = bank_n;
            if (frame_en) begin
               act_d     = div_ok;
               pix_d     = '0;
               wr_load_d = div_ok;
            end else begin
               state_d = ARM;
               act_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      // Losing camera config abandons the frame in flight without reporting it.
      if (!init_done) begin
         state_d   = IDLE;
         act_d     = 1'b0;
         wr_en_d   = 1'b0;
         wr_load_d = 1'b0;
         done_d    = 1'b0;
         wr_bank_d = wr_bank_q;
         fcnt_d    = fcnt_q;
         ecnt_d    = ecnt_q;
      end
   end

   always_ff @(posedge cam_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         vsync_q   <= 1'b0;
         skip_q    <= '0;
         pix_q     <= '0;
         act_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         wr_load_q <= 1'b0;
         wr_bank_q <= 1'b0;
         done_q    <= 1'b0;
         fcnt_q    <= '0;
         ecnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         vsync_q   <= cmos_frame_vsync;
         skip_q    <= skip_d;
         pix_q     <= pix_d;
         act_q     <= act_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         wr_load_q <= wr_load_d;
         wr_bank_q <= wr_bank_d;
         done_q    <= done_d;
         fcnt_q    <= fcnt_d;
         ecnt_q    <= ecnt_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_data    = wr_data_q;
   assign wr_load    = wr_load_q;
   assign wr_bank    = wr_bank_q;
   assign frame_done = done_q;
   assign frame_cnt  = fcnt_q;
   assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_cmos_frame_ctrl.sv
// Directed bench for cmos_frame_ctrl with FRAME_SKIP=2 and 16-pixel frames.
module tb_cmos_frame_ctrl;

   logic        cam_pclk = 1'b0;
   logic        rst_n;
   logic        init_done, frame_en, rd_busy;
   logic        cmos_frame_vsync, cmos_frame_valid;
   logic [15:0] cmos_frame_data;
   logic [27:0] sdram_addr_max;
   logic        wr_en, wr_load, wr_bank, frame_done;
   logic [15:0] wr_data, frame_cnt;
   logic [7:0]  err_cnt;

   int n_pass = 0;
   int n_tot  = 0;

   cmos_frame_ctrl #(.FRAME_SKIP(2), .FRAME_DIV(2)) dut (
      .cam_pclk(cam_pclk), .rst_n(rst_n), .init_done(init_done), .frame_en(frame_en),
      .rd_busy(rd_busy), .cmos_frame_vsync(cmos_frame_vsync),
      .cmos_frame_valid(cmos_frame_valid), .cmos_frame_data(cmos_frame_data),
      .sdram_addr_max(sdram_addr_max), .wr_en(wr_en), .wr_data(wr_data),
      .wr_load(wr_load), .wr_bank(wr_bank), .frame_done(frame_done),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   always #5 cam_pclk = ~cam_pclk;

   // Apply one cycle of inputs; on return the registered outputs reflect them.
   task automatic cyc(input logic vs, input logic v, input logic [15:0] d);
      cmos_frame_vsync = vs;
      cmos_frame_valid = v;
      cmos_frame_data  = d;
      @(posedge cam_pclk);
      #1;
   endtask

   task automatic pixels(input string nm, input int n, input logic exp_wr, input logic [15:0] base);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         cyc(1'b0, 1'b1, base + 16'(i));
         if (wr_en !== exp_wr || (exp_wr && wr_data !== base + 16'(i))) bad++;
      end
      n_tot++;
      if (bad != 0) $display("FAIL %s: %0d pixel beats with wrong wr_en/wr_data (wanted wr_en=%0b)", nm, bad, exp_wr);
      else n_pass++;
   endtask

   task automatic body(input string nm, input int n, input logic exp_wr);
      cyc(1'b0, 1'b0, 16'h0);
      pixels(nm, n, exp_wr, 16'hA000 + 16'(n));
      cyc(1'b0, 1'b0, 16'h0);
   endtask

   // Frame boundary, then compare the evaluation pulses and counters.
   task automatic vs_chk(input string nm, input logic e_load, input logic e_done,
                         input logic e_bank, input logic [15:0] e_fc, input logic [7:0] e_ec);
      cyc(1'b1, 1'b0, 16'h0);
      n_tot++;
      if (wr_load !== e_load || frame_done !== e_done || wr_bank !== e_bank ||
          frame_cnt !== e_fc || err_cnt !== e_ec)
         $display("FAIL %s: got load=%0b done=%0b bank=%0b fcnt=%0d ecnt=%0d, want %0b %0b %0b %0d %0d",
                  nm, wr_load, frame_done, wr_bank, frame_cnt, err_cnt,
                  e_load, e_done, e_bank, e_fc, e_ec);
      else n_pass++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; init_done = 1'b0; frame_en = 1'b0; rd_busy = 1'b0;
      cmos_frame_vsync = 1'b0; cmos_frame_valid = 1'b0; cmos_frame_data = '0;
      sdram_addr_max = 28'd16;
      repeat (3) @(posedge cam_pclk);
      #2 rst_n = 1'b1;
      cyc(1'b0, 1'b0, 16'h0);
   endtask

   task automatic test_reset();
      do_reset();
      n_tot++;
      if ({wr_en, wr_data, wr_load, wr_bank, frame_done, frame_cnt, err_cnt} !== '0)
         $display("FAIL reset: outputs %h, want all zero",
                  {wr_en, wr_data, wr_load, wr_bank, frame_done, frame_cnt, err_cnt});
      else n_pass++;
   endtask

   task automatic test_skip_first_frame();
      init_done = 1'b1; frame_en = 1'b1;
      cyc(1'b0, 1'b0, 16'h0);
      vs_chk("skip vs1", 0, 0, 0, 0, 0);
      body("skip frame1", 16, 1'b0);
      vs_chk("skip vs2", 0, 0, 0, 0, 0);
      body("skip frame2", 16, 1'b0);
      vs_chk("arm vs3 load", 1, 0, 0, 0, 0);
      body("first capt", 16, 1'b1);
      vs_chk("first done", 1, 1, 1, 1, 0);
   endtask

   task automatic test_good_frames();
      body("good a", 16, 1'b1);
      vs_chk("good bank0", 1, 1, 0, 2, 0);
      body("good b", 16, 1'b1);
      vs_chk("good bank1", 1, 1, 1, 3, 0);
      body("good c", 16, 1'b1);
      vs_chk("good bank0 again", 1, 1, 0, 4, 0);
   endtask

   task automatic test_bad_frames();
      body("short", 15, 1'b1);
      vs_chk("short frame", 1, 0, 0, 4, 1);
      body("recover", 16, 1'b1);
      vs_chk("recover toggle", 1, 1, 1, 5, 1);
      body("long", 17, 1'b1);
      vs_chk("long frame", 1, 0, 1, 5, 2);
   endtask

   task automatic test_rd_busy();
      body("busy", 16, 1'b1);
      rd_busy = 1'b1;
      vs_chk("busy hold bank", 1, 1, 1, 6, 2);
      rd_busy = 1'b0;
   endtask

   task automatic test_pix_on_vsrise();
      body("edge pix", 15, 1'b1);
      cyc(1'b1, 1'b1, 16'h5A5A);
      n_tot++;
      if (wr_en !== 1'b1 || wr_data !== 16'h5A5A || frame_done !== 1'b1 ||
          frame_cnt !== 16'd7 || wr_bank !== 1'b0 || wr_load !== 1'b1)
         $display("FAIL pix on vs_rise: en=%0b data=%h done=%0b fcnt=%0d bank=%0b load=%0b, want 1 5a5a 1 7 0 1",
                  wr_en, wr_data, frame_done, frame_cnt, wr_bank, wr_load);
      else n_pass++;
   endtask

   task automatic test_frame_en_drop();
      cyc(1'b0, 1'b0, 16'h0);
      pixels("drop first half", 8, 1'b1, 16'h1000);
      frame_en = 1'b0;
      pixels("drop second half", 8, 1'b1, 16'h2000);
      cyc(1'b0, 1'b0, 16'h0);
      vs_chk("drop completes", 0, 1, 1, 8, 2);
      body("armed idle", 16, 1'b0);
      vs_chk("armed no load", 0, 0, 1, 8, 2);
      frame_en = 1'b1;
      body("armed idle2", 16, 1'b0);
      vs_chk("rearm load", 1, 0, 1, 8, 2);
   endtask

   task automatic test_init_drop();
      cyc(1'b0, 1'b0, 16'h0);
      pixels("pre drop", 5, 1'b1, 16'h3000);
      init_done = 1'b0;
      cyc(1'b0, 1'b1, 16'h3005);
      n_tot++;
      if (wr_en !== 1'b0) $display("FAIL init drop wr_en: got %0b want 0", wr_en);
      else n_pass++;
      pixels("init low", 4, 1'b0, 16'h3100);
      cyc(1'b0, 1'b0, 16'h0);
      vs_chk("init low boundary", 0, 0, 1, 8, 2);
      init_done = 1'b1;
      body("reskip1", 16, 1'b0);
      vs_chk("reskip vs1", 0, 0, 1, 8, 2);
      body("reskip2", 16, 1'b0);
      vs_chk("reskip vs2", 0, 0, 1, 8, 2);
      body("reskip3", 16, 1'b0);
      vs_chk("reskip load", 1, 0, 1, 8, 2);
   endtask

   task automatic test_reset_mid();
      cyc(1'b0, 1'b0, 16'h0);
      pixels("pre reset", 4, 1'b1, 16'h4000);
      #2 rst_n = 1'b0;
      #1;
      n_tot++;
      if ({wr_en, wr_load, wr_bank, frame_done, frame_cnt, err_cnt} !== '0)
         $display("FAIL async reset: en=%0b load=%0b bank=%0b done=%0b fcnt=%0d ecnt=%0d, want all 0",
                  wr_en, wr_load, wr_bank, frame_done, frame_cnt, err_cnt);
      else n_pass++;
      @(negedge cam_pclk) rst_n = 1'b1;
   endtask

`ifdef FRAME_DIV_EN
   task automatic test_frame_div();
      int loads = 0;
      init_done = 1'b1; frame_en = 1'b1;
      cyc(1'b0, 1'b0, 16'h0);
      vs_chk("div skip1", 0, 0, 0, 0, 0);
      body("div s1", 16, 1'b0);
      vs_chk("div skip2", 0, 0, 0, 0, 0);
      for (int f = 0; f < 6; f++) begin
         body("div idle", 16, 1'bx);
         cyc(1'b1, 1'b0, 16'h0);
         if (wr_load === 1'b1) loads++;
      end
      cyc(1'b0, 1'b0, 16'h0);
      n_tot++;
      if (loads != 3 || frame_cnt !== 16'd3)
         $display("FAIL frame div: loads=%0d fcnt=%0d, want 3 3", loads, frame_cnt);
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
`ifdef FRAME_DIV_EN
      test_frame_div();
`else
      test_skip_first_frame();
      test_good_frames();
      test_bad_frames();
      test_rd_busy();
      test_pix_on_vsrise();
      test_frame_en_drop();
      test_init_drop();
      test_reset_mid();
`endif
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
